// File: rtl/dm_lane_pipe.sv
// Byte-addressable data memory with valid/ready request port and a single-pulse response.
// Latency: stores respond 1 cycle after accept, loads READ_LAT cycles after accept.
// Backpressure: req_ready drops while a multi-cycle load is in flight; responses are never stalled.
//
// Ports:
//   clk, rstn                  clock (rising edge) and asynchronous active-low reset
//   req_valid / req_ready      request handshake; accept when both high at a rising edge
//   req_we, req_addr, req_size store/load select, byte address, access size (00 B, 01 H, 1x W)
//   req_unsigned, req_wdata    load zero-extend select, right-justified store data
//   rsp_valid, rsp_rdata       one-cycle response pulse and load result (0 for stores/errors)
//   rsp_err                    access rejected, memory untouched
//
// Build option: define DM_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
// Without it, halves are forced to offset {o[1],0} and words ignore the offset.

module dm_lane_pipe #(
  parameter int DEPTH_WORDS = 128,
  parameter int ADDR_W      = 9,
  parameter int READ_LAT    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int WI = $clog2(DEPTH_WORDS);

  // Elaboration-time parameter sanity checks.
  generate
    if ((1 << WI) != DEPTH_WORDS) begin : g_bad_depth
      $error("dm_lane_pipe: DEPTH_WORDS must be a power of two");
    end
    if (ADDR_W < WI + 2) begin : g_bad_addr
      $error("dm_lane_pipe: ADDR_W too narrow for DEPTH_WORDS");
    end
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
      $error("dm_lane_pipe: READ_LAT must be 1..4");
    end
  endgenerate

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] pend_rdata;
  logic        pend_err;

  logic [31:0] mem [DEPTH_WORDS];

  logic          acc;
  logic [WI-1:0] widx;
  logic [1:0]    off;
  logic          oor;
  logic          err;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   ld_data;

  assign req_ready = (state == IDLE);
  assign acc       = req_valid && req_ready;
  assign widx      = req_addr[WI+1:2];
  assign off       = req_addr[1:0];

  // Any address bits above the array's word index make the access out of range.
  // With ADDR_W matched to DEPTH_WORDS this can never fire.
  assign oor = ((32'(req_addr) >> 2) >= 32'(DEPTH_WORDS));

`ifdef DM_MISALIGN_TRAP_EN
  logic misal;
  always_comb begin
    misal = 1'b0;
    case (req_size)
      2'b00:   misal = 1'b0;
      2'b01:   misal = off[0];
      default: misal = (off != 2'b00);
    endcase
  end
  assign err = oor | misal;
`else
  assign err = oor;
`endif

  // Store lane enables and lane-replicated write data. Replicating the
  // right-justified data across the word lets the byte enables pick the lane.
  always_comb begin
    be    = 4'b0000;
    wlane = req_wdata;
    case (req_size)
      2'b00: begin
        be    = 4'b0001 << off;
        wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wlane = {2{req_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = req_wdata;
      end
    endcase
  end

  // Load path: read the addressed word at accept time and extract/extend the lane.
  always_comb begin
    rword   = mem[widx];
    rbyte   = rword[{off, 3'b000} +: 8];
    rhalf   = rword[{off[1], 4'b0000} +: 16];
    ld_data = rword;
    case (req_size)
      2'b00:   ld_data = req_unsigned ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   ld_data = req_unsigned ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: ld_data = rword;
    endcase
    if (err) begin
      ld_data = 32'b0;
    end
  end

  // Array has no reset; only the lanes selected by be are written.
  always_ff @(posedge clk) begin
    if (acc && req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[widx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered response outputs. Multi-cycle loads park their
  // result in pend_* and release it when the down-counter reaches 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      pend_rdata <= 32'b0;
      pend_err   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'b0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            if (!req_we && (READ_LAT > 1)) begin
              state      <= BUSY;
              cnt        <= 3'(READ_LAT - 1);
              pend_rdata <= ld_data;
              pend_err   <= err;
            end else begin
              rsp_valid <= 1'b1;
              rsp_rdata <= req_we ? 32'b0 : ld_data;
              rsp_err   <= err;
            end
          end
        end
        BUSY: begin
          if (cnt == 3'd1) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            rsp_valid <= 1'b1;
            rsp_rdata <= pend_rdata;
            rsp_err   <= pend_err;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

endmodule
